// File: rtl/gate_op_arbiter_if.sv
// Request/response bundle between N requesters, the consumer and the shared gate-op arbiter.
interface gate_op_arbiter_if #(
    parameter int N     = 4,
    parameter int WIDTH = 8,
    parameter int IDW   = 2
);
    logic [N-1:0]       req_valid;
    logic [2*N-1:0]     req_op;
    logic [WIDTH*N-1:0] req_a;
    logic [WIDTH*N-1:0] req_b;
    logic [N-1:0]       req_ready;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [IDW-1:0]     rsp_id;
    logic [WIDTH-1:0]   rsp_data;
    logic               rsp_err;

    // Requesters/consumer side
    modport master (
        output req_valid, req_op, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_err
    );

    // Arbiter side
    modport slave (
        input  req_valid, req_op, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_data, rsp_err
    );
endinterface

// File: rtl/gate_op_arbiter.sv
// Round-robin arbiter that shares one AND/OR/NOT unit among N requesters.
// IDLE grants and latches a request, EXEC evaluates and registers the
// result, RESP holds it until the consumer takes it.
module gate_op_arbiter #(
    parameter int N     = 4,
    parameter int WIDTH = 8,
    parameter int IDW   = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    gate_op_arbiter_if.slave    bus,
    output logic                busy,
    output logic [15:0]         done_count
);
    typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

    state_t           state_q, state_d;
    logic [IDW-1:0]   rr_ptr_q;
    logic [IDW-1:0]   id_q;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic [IDW-1:0]   rsp_id_q;
    logic [WIDTH-1:0] rsp_data_q;
    logic             rsp_err_q;
    logic [15:0]      done_count_q;

    logic [2*N-1:0]   vld_rot;
    logic [IDW:0]     cand;
    logic             gnt_found;
    logic [IDW-1:0]   gnt_id;
    logic [1:0]       sel_op;
    logic [WIDTH-1:0] sel_a, sel_b;
    logic [WIDTH-1:0] exec_res;

    // Grant search: rotate valids so bit 0 is rr_ptr, take the first set bit,
    // then map the rotated position back to a requester index.
    always_comb begin
        vld_rot   = {bus.req_valid, bus.req_valid} >> rr_ptr_q;
        gnt_found = 1'b0;
        gnt_id    = '0;
        cand      = '0;
        for (int i = 0; i < N; i++) begin
            cand = {1'b0, rr_ptr_q} + (IDW+1)'(i);
            if (cand >= (IDW+1)'(N))
                cand = cand - (IDW+1)'(N);
            if (!gnt_found && vld_rot[i]) begin
                gnt_found = 1'b1;
                gnt_id    = cand[IDW-1:0];
            end
        end
    end

    // Operand mux for the granted requester plus the one-hot accept. Accept is
    // also gated by rst_n so req_ready reads 0 for the whole reset window.
    always_comb begin
        sel_op        = '0;
        sel_a         = '0;
        sel_b         = '0;
        bus.req_ready = '0;
        for (int i = 0; i < N; i++) begin
            if (gnt_id == IDW'(i)) begin
                sel_op = bus.req_op[2*i +: 2];
                sel_a  = bus.req_a[WIDTH*i +: WIDTH];
                sel_b  = bus.req_b[WIDTH*i +: WIDTH];
                bus.req_ready[i] = rst_n && (state_q == IDLE) && gnt_found;
            end
        end
    end

    // Gate evaluation on the latched operands; reserved opcode yields zero.
    always_comb begin
        case (op_q)
            2'b00:   exec_res = a_q & b_q;
            2'b01:   exec_res = a_q | b_q;
            2'b10:   exec_res = ~a_q;
            default: exec_res = '0;
        endcase
    end

    // Next-state: one grant cycle, one fixed execute cycle, hold until taken.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (gnt_found) state_d = EXEC;
            EXEC:    state_d = RESP;
            RESP:    if (bus.rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Request latch, result register, pointer and completion counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q     <= '0;
            id_q         <= '0;
            op_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            rsp_id_q     <= '0;
            rsp_data_q   <= '0;
            rsp_err_q    <= 1'b0;
            done_count_q <= '0;
        end else begin
            case (state_q)
                IDLE: if (gnt_found) begin
                    op_q     <= sel_op;
                    a_q      <= sel_a;
                    b_q      <= sel_b;
                    id_q     <= gnt_id;
                    rr_ptr_q <= (gnt_id == IDW'(N-1)) ? '0 : gnt_id + 1'b1;
                end
                EXEC: begin
                    rsp_data_q <= exec_res;
                    rsp_id_q   <= id_q;
                    rsp_err_q  <= (op_q == 2'b11);
                end
                RESP: if (bus.rsp_ready) done_count_q <= done_count_q + 16'd1;
                default: ;
            endcase
        end
    end

    assign bus.rsp_valid = (state_q == RESP);
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_err   = rsp_err_q;
    assign busy          = (state_q != IDLE);
    assign done_count    = done_count_q;
endmodule

// File: tb/tb_gate_op_arbiter.sv
// Scoreboard bench for gate_op_arbiter: grants are predicted by a queue-level
// round-robin model, expected results are pushed at accept time and popped
// by the monitor when the response appears.
module tb_gate_op_arbiter;
    localparam int N = 4;
    localparam int W = 8;
    localparam int IDW = 2;

    logic clk = 1'b0;
    logic rst_n;
    logic busy;
    logic [15:0] done_count;

    gate_op_arbiter_if #(.N(N), .WIDTH(W), .IDW(IDW)) bus ();

    gate_op_arbiter #(.N(N), .WIDTH(W), .IDW(IDW)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .busy(busy), .done_count(done_count)
    );

    always #5 clk = ~clk;

    // Requester-side held state
    logic [N-1:0] vld;
    logic [1:0]   op_h [N];
    logic [W-1:0] a_h  [N];
    logic [W-1:0] b_h  [N];
    logic         rdy;

    always_comb begin
        bus.req_valid = vld;
        bus.rsp_ready = rdy;
        bus.req_op    = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        for (int i = 0; i < N; i++) begin
            bus.req_op[2*i +: 2] = op_h[i];
            bus.req_a[W*i +: W]  = a_h[i];
            bus.req_b[W*i +: W]  = b_h[i];
        end
    end

    typedef struct {
        int           id;
        logic [W-1:0] data;
        logic         err;
        int           due;
    } exp_t;

    exp_t  q[$];
    exp_t  cur;
    int    n_cmp = 0;
    int    n_bad = 0;
    int    cyc = 0;
    int    exp_ptr = 0;
    int    last_acc = -1;
    logic [15:0] exp_done = 16'd0;
    bit    chk_en = 1'b0;
    bit    in_rsp = 1'b0;
    bit    done_pend = 1'b0;
    bit    rr_mode = 1'b0;
    logic [N-1:0] acc_mask = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [W-1:0] ref_res(input logic [1:0] op, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
        case (op)
            2'd0:    return a & b;
            2'd1:    return a | b;
            2'd2:    return ~a;
            default: return '0;
        endcase
    endfunction

    // First valid requester at or after ptr, wrapping; -1 when none.
    function automatic int pick(input logic [N-1:0] v, input int ptr);
        for (int k = 0; k < N; k++) begin
            int j = (ptr + k) % N;
            if (v[j]) return j;
        end
        return -1;
    endfunction

    // Monitor / scoreboard
    always @(negedge clk) begin
        int   outstanding;
        int   gi;
        logic [N-1:0] emask;
        exp_t e;
        acc_mask = bus.req_ready;
        if (chk_en) begin
            if (done_pend) begin
                chk("done_count", 32'(done_count), 32'(exp_done));
                done_pend = 1'b0;
            end
            outstanding = q.size() + (in_rsp ? 1 : 0);
            chk("busy", 32'(busy), 32'(outstanding != 0));
            if (outstanding != 0) begin
                chk("ready_while_busy", 32'(bus.req_ready), 32'd0);
            end else begin
                gi = pick(vld, exp_ptr);
                emask = (gi < 0) ? '0 : (N'(1) << gi);
                chk("grant", 32'(bus.req_ready), 32'(emask));
                if (gi >= 0) begin
                    e.id   = gi;
                    e.data = ref_res(op_h[gi], a_h[gi], b_h[gi]);
                    e.err  = (op_h[gi] == 2'd3);
                    e.due  = cyc + 2;
                    q.push_back(e);
                    exp_ptr = (gi + 1) % N;
                    if (rr_mode && last_acc >= 0)
                        chk("rr_spacing", 32'(cyc - last_acc), 32'd3);
                    last_acc = cyc;
                end
            end
            if (bus.rsp_valid) begin
                if (!in_rsp) begin
                    if (q.size() == 0) begin
                        chk("unexpected_rsp", 32'(bus.rsp_valid), 32'd0);
                    end else begin
                        cur = q.pop_front();
                        chk("latency_cycle", 32'(cyc), 32'(cur.due));
                        in_rsp = 1'b1;
                    end
                end
                if (in_rsp) begin
                    chk("rsp_id", 32'(bus.rsp_id), 32'(cur.id));
                    chk("rsp_data", 32'(bus.rsp_data), 32'(cur.data));
                    chk("rsp_err", 32'(bus.rsp_err), 32'(cur.err));
                    if (rdy) begin
                        in_rsp    = 1'b0;
                        exp_done  = exp_done + 16'd1;
                        done_pend = 1'b1;
                    end
                end
            end else if (q.size() > 0 && q[0].due <= cyc) begin
                chk("rsp_missing", 32'(bus.rsp_valid), 32'd1);
                void'(q.pop_front());
            end
        end
    end

    // One cycle of stimulus: retire accepted requests, optionally raise new ones.
    task automatic step(input int p_new, input int p_rdy, input bit all_on);
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++)
            if (acc_mask[i]) vld[i] = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!vld[i] && (all_on || $urandom_range(99) < p_new)) begin
                vld[i]  = 1'b1;
                op_h[i] = 2'($urandom_range(3));
                a_h[i]  = W'($urandom);
                b_h[i]  = W'($urandom);
            end
        end
        rdy = ($urandom_range(99) < p_rdy);
    endtask

    task automatic put(input int i, input logic [1:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b);
        vld[i]  = 1'b1;
        op_h[i] = op;
        a_h[i]  = a;
        b_h[i]  = b;
    endtask

    task automatic drain();
        for (int k = 0; k < 60; k++) begin
            if (vld == '0 && q.size() == 0 && !in_rsp && !busy) break;
            step(0, 100, 1'b0);
        end
        chk("drain_idle", {30'd0, busy, (vld != '0)}, 32'd0);
    endtask

    initial begin
        int k;
        rst_n = 1'b0;
        rdy   = 1'b0;
        vld   = '1;
        for (int i = 0; i < N; i++) begin
            op_h[i] = '0; a_h[i] = '0; b_h[i] = '0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_rsp_id", 32'(bus.rsp_id), 32'd0);
        chk("rst_rsp_data", 32'(bus.rsp_data), 32'd0);
        chk("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done_count", 32'(done_count), 32'd0);
        vld = '0;
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        chk_en = 1'b1;

        // Round robin with every requester continuously valid
        rr_mode  = 1'b1;
        last_acc = -1;
        repeat (16) step(0, 100, 1'b1);
        rr_mode = 1'b0;
        drain();

        // Single request and opcode coverage
        put(2, 2'd0, 8'hF0, 8'h3C); rdy = 1'b1; drain();
        put(0, 2'd1, 8'hA0, 8'h05); drain();
        put(0, 2'd2, 8'h0F, 8'h77); drain();
        put(0, 2'd3, 8'hFF, 8'hFF); drain();

        // Backpressure: hold rsp_ready low for 5 cycles in RESP
        put(1, 2'd1, 8'h12, 8'h40);
        rdy = 1'b0;
        for (k = 0; k < 10; k++) begin
            if (bus.rsp_valid) break;
            step(0, 0, 1'b0);
        end
        chk("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        repeat (5) step(0, 0, 1'b0);
        step(0, 100, 1'b0);
        step(0, 100, 1'b0);
        chk("bp_back_idle", {30'd0, busy, bus.rsp_valid}, 32'd0);
        drain();

        // Randomized traffic with random backpressure
        repeat (400) step(30, 60, 1'b0);
        drain();

        // Reset during EXEC
        put(0, 2'd0, 8'h5A, 8'hFF);
        rdy = 1'b1;
        for (k = 0; k < 5; k++) begin
            if (busy) break;
            step(0, 100, 1'b0);
        end
        chk("pre_rst_busy", 32'(busy), 32'd1);
        vld[1] = 1'b1; vld[3] = 1'b1;
        chk_en = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_req_ready", 32'(bus.req_ready), 32'd0);
        chk("mid_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("mid_rst_rsp_id", 32'(bus.rsp_id), 32'd0);
        chk("mid_rst_rsp_data", 32'(bus.rsp_data), 32'd0);
        chk("mid_rst_rsp_err", 32'(bus.rsp_err), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_done_count", 32'(done_count), 32'd0);
        q.delete();
        in_rsp    = 1'b0;
        done_pend = 1'b0;
        exp_ptr   = 0;
        exp_done  = 16'd0;
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        chk_en = 1'b1;
        @(negedge clk);
        chk("post_rst_first_grant", 32'(bus.req_ready), 32'b0010);
        drain();

        // Counter wrap: preload 0xFFFF, one more completion must give 0
        force dut.done_count_q = 16'hFFFF;
        exp_done = 16'hFFFF;
        @(negedge clk);
        chk("preload_count", 32'(done_count), 32'hFFFF);
        release dut.done_count_q;
        @(posedge clk);
        #1;
        put(2, 2'd1, 8'h55, 8'hAA);
        rdy = 1'b1;
        drain();
        chk("wrap_count", 32'(done_count), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d compared so far", n_cmp);
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/gate_op_arbiter.md
# gate_op_arbiter

Round-robin arbiter and sequencer that shares one bitwise logic unit (AND, OR, NOT) among N requesters. Each requester presents an opcode and operands through a valid/ready handshake. The arbiter grants one requester at a time, latches its operands, evaluates the gate operation in a dedicated cycle and returns a tagged result through a response handshake. It sits between the requesting blocks and the shared gate datapath, and is the only path to that datapath.

## Interface
Parameters:
- `N`, 4: number of requesters, 2..8.
- `WIDTH`, 8: operand/result width in bits.
- `IDW`, 2: requester-id width; must satisfy 2^IDW >= N.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  N  per-requester request valid.
- `req_op`  in  2*N  opcode, requester i at bits [2i+1:2i]: 00 AND, 01 OR, 10 NOT a, 11 reserved.
- `req_a`  in  WIDTH*N  operand a, requester i at bits [WIDTH*i+WIDTH-1:WIDTH*i].
- `req_b`  in  WIDTH*N  operand b, same packing; ignored for NOT.
- `req_ready`  out  N  one-hot grant/accept; at most one bit high.
- `rsp_valid`  out  1  result available.
- `rsp_ready`  in  1  consumer accepts result.
- `rsp_id`  out  IDW  index of the requester that owns the result.
- `rsp_data`  out  WIDTH  result.
- `rsp_err`  out  1  opcode was reserved (11).
- `busy`  out  1  high whenever the state is not IDLE.
- `done_count`  out  16  count of completed responses; wraps.

## Operation
- The FSM has three states: IDLE, EXEC and RESP. Reset state is IDLE.
- IDLE:
  - If any `req_valid` is high, the grant goes to the first valid index found scanning upward from `rr_ptr`, wrapping modulo N.
  - `req_ready[grant]` is driven high combinationally in this cycle, which completes the request handshake.
  - At the clock edge the arbiter latches op, a, b and grant id, sets `rr_ptr <= (grant+1) mod N`, and moves to EXEC.
  - If no `req_valid` is high, all `req_ready` bits are low and the FSM stays in IDLE.
- EXEC:
  - The result is computed and registered. AND gives a&b, OR gives a|b, NOT gives ~a.
  - Opcode 11 gives `rsp_data` = 0 and `rsp_err` = 1. The other opcodes give `rsp_err` = 0.
  - `rsp_id` is loaded from the latched grant id.
  - The FSM always moves to RESP after exactly one cycle.
- RESP:
  - `rsp_valid` = 1. `rsp_data`, `rsp_id` and `rsp_err` are held stable until the handshake.
  - On a cycle with `rsp_valid` && `rsp_ready`: `done_count` increments (0xFFFF wraps to 0) and the FSM returns to IDLE.
- `req_ready` is 0 in EXEC and RESP. Requests that arrive while busy wait; requesters hold their `req_valid`, op and operands until `req_ready`.
- A `req_valid` withdrawn before its grant is simply never granted; no state is kept per requester.
- Fairness: a requester that stays continuously valid is granted within N arbitrations.

## Timing
- Reset values: `req_ready` = 0, `rsp_valid` = 0, `rsp_id` = 0, `rsp_data` = 0, `rsp_err` = 0, `busy` = 0, `done_count` = 0, `rr_ptr` = 0, state = IDLE.
- Latency: a request accepted in cycle T gives `rsp_valid` = 1 in cycle T+2.
- Throughput: with `rsp_ready` held high, one request completes every 3 cycles.
- `req_ready` depends combinationally on `req_valid` and `rr_ptr`. No other output is combinational from inputs.
- `rsp_ready` high while `rsp_valid` is low is ignored.
- Asserting `rst_n` low mid-operation (in EXEC or RESP) immediately clears all state to the reset values. The in-flight operation is discarded and is not counted.
- After `rst_n` deasserts, the first grant scans from index 0.

## Test plan
- Single request: requester 2 sends op=00, a=0xF0, b=0x3C. Required: `req_ready` = 0b0100 in cycle T; `rsp_valid` in cycle T+2 with `rsp_data`=0x30, `rsp_id`=2, `rsp_err`=0; `done_count`=1 after the handshake.
- Opcode coverage: op=01 with a=0xA0, b=0x05 gives 0xA5. op=10 with a=0x0F gives 0xF0. op=11 gives `rsp_data`=0x00 with `rsp_err`=1.
- Round robin: all 4 requesters hold valid continuously with `rsp_ready`=1. Required grant order is 0,1,2,3,0 at accept cycles T, T+3, T+6, T+9, T+12.
- Backpressure: `rsp_ready` is held 0 for 5 cycles while in RESP. Required: `rsp_valid` stays 1 with stable data, all `req_ready` bits stay 0, and the FSM returns to IDLE in the cycle after `rsp_ready` rises.
- Reset mid-operation: pull `rst_n` low during EXEC. Required: all outputs return to reset values asynchronously; after release, requesters 1 and 3 valid gives requester 1 granted first.
- Counter wrap: preload 65535 completions via fast-forward or force. Required: the next response gives `done_count`=0.
